// File: rtl/mesi_pkg.sv
// Shared MESI/MOESI encodings for the L2 line controller: states, commands,
// bus operations, snoop results and the next-state result record.
package mesi_pkg;

    localparam logic [2:0] ST_M = 3'd0;
    localparam logic [2:0] ST_E = 3'd1;
    localparam logic [2:0] ST_S = 3'd2;
    localparam logic [2:0] ST_I = 3'd3;
    localparam logic [2:0] ST_O = 3'd4;

    localparam logic [3:0] CMD_DRD  = 4'd0;
    localparam logic [3:0] CMD_DWR  = 4'd1;
    localparam logic [3:0] CMD_IRD  = 4'd2;
    localparam logic [3:0] CMD_SINV = 4'd3;
    localparam logic [3:0] CMD_SRD  = 4'd4;
    localparam logic [3:0] CMD_SWR  = 4'd5;
    localparam logic [3:0] CMD_SRFO = 4'd6;
    localparam logic [3:0] CMD_CLR  = 4'd8;

    localparam logic [2:0] BUS_NOP = 3'd0;
    localparam logic [2:0] BUS_MRD = 3'd1;
    localparam logic [2:0] BUS_MWR = 3'd2;
    localparam logic [2:0] BUS_RFO = 3'd3;
    localparam logic [2:0] BUS_INV = 3'd4;

    localparam logic [1:0] SNP_NOHIT = 2'd0;
    localparam logic [1:0] SNP_HIT   = 2'd1;
    localparam logic [1:0] SNP_HITM  = 2'd2;

    typedef struct packed {
        logic [2:0] next;
        logic [2:0] busop;
        logic       err;
    } ns_t;

    localparam ns_t NS_IDLE = '{next: ST_I, busop: BUS_NOP, err: 1'b0};

    function automatic logic is_l1_read(input logic [3:0] cmd);
        return (cmd == CMD_DRD) || (cmd == CMD_IRD);
    endfunction

    function automatic logic is_snoop(input logic [3:0] cmd);
        return (cmd == CMD_SINV) || (cmd == CMD_SRD) || (cmd == CMD_SWR) || (cmd == CMD_SRFO);
    endfunction

endpackage

// File: rtl/mesi_next_state.sv
// Combinational MESI/MOESI transition function: (state, cmd, snoop) -> next
// state, required bus operation and illegal-combination flag.
module mesi_next_state
    import mesi_pkg::*;
#(
    parameter bit MOESI_EN = 1'b0
) (
    input  logic [2:0] state_i,
    input  logic [3:0] cmd_i,
    input  logic [1:0] snoop_i,
    output ns_t        ns_o
);

    logic rd, wr, known;

    always_comb begin
        rd    = is_l1_read(cmd_i);
        wr    = (cmd_i == CMD_DWR);
        known = rd || wr || is_snoop(cmd_i);

        ns_o.next  = state_i;
        ns_o.busop = BUS_NOP;
        ns_o.err   = 1'b0;

        if (!known) begin
            ns_o.err = 1'b1;
        end else begin
            case (state_i)
                ST_I: begin
                    // Fill outcome depends on the snoop result returned with the ack
                    if (rd) begin
                        ns_o.busop = BUS_MRD;
                        ns_o.next  = (snoop_i == SNP_NOHIT) ? ST_E : ST_S;
                    end else if (wr) begin
                        ns_o.busop = BUS_RFO;
                        ns_o.next  = ST_M;
                    end
                end
                ST_E: begin
                    if (wr)                     ns_o.next = ST_M;
                    else if (cmd_i == CMD_SRD)  ns_o.next = ST_S;
                    else if (cmd_i == CMD_SRFO) ns_o.next = ST_I;
                    else if (!rd)               ns_o.err  = 1'b1;
                end
                ST_S: begin
                    if (wr) begin
                        ns_o.next  = ST_M;
                        ns_o.busop = BUS_INV;
                    end else if (cmd_i == CMD_SINV || cmd_i == CMD_SRFO) begin
                        ns_o.next = ST_I;
                    end else if (cmd_i == CMD_SWR) begin
                        ns_o.err = 1'b1;
                    end
                end
                ST_M: begin
                    if (cmd_i == CMD_SRD) begin
                        if (MOESI_EN) begin
                            ns_o.next = ST_O;
                        end else begin
                            ns_o.next  = ST_S;
                            ns_o.busop = BUS_MWR;
                        end
                    end else if (cmd_i == CMD_SRFO) begin
                        ns_o.next  = ST_I;
                        ns_o.busop = BUS_MWR;
                    end else if (cmd_i == CMD_SWR || cmd_i == CMD_SINV) begin
                        ns_o.err = 1'b1;
                    end
                end
                ST_O: begin
                    if (!MOESI_EN) begin
                        ns_o.err = 1'b1;
                    end else if (cmd_i == CMD_SRFO) begin
                        ns_o.next  = ST_I;
                        ns_o.busop = BUS_MWR;
                    end else if (wr) begin
                        ns_o.next  = ST_M;
                        ns_o.busop = BUS_INV;
                    end else if (cmd_i == CMD_SWR || cmd_i == CMD_SINV) begin
                        ns_o.err = 1'b1;
                    end
                end
                default: ns_o.err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mesi_line_controller.sv
// Sequential MESI/MOESI controller for an array of L2 line states: accepts one
// command at a time, runs the bus operation, commits and reports the new state.
module mesi_line_controller
    import mesi_pkg::*;
#(
    parameter int NUM_LINES = 64,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter bit MOESI_EN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cmd,
    input  logic [IDX_W-1:0] req_idx,
    output logic             bus_valid,
    output logic [2:0]       bus_op,
    output logic [IDX_W-1:0] bus_idx,
    input  logic             bus_ack,
    input  logic [1:0]       bus_snoop,
    output logic             resp_valid,
    output logic [2:0]       resp_state,
    output logic             resp_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_EVAL   = 3'd1;
    localparam logic [2:0] S_BUS    = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_CLEAR  = 3'd4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

    logic [2:0]       fsm_q, fsm_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] clr_q, clr_d;
    ns_t              ns_q, ns_d;
    logic [2:0]       lines_q [NUM_LINES];

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [2:0]       wr_state;
    logic [2:0]       cur_state;
    ns_t              ns_eval, ns_ack;

    assign cur_state = lines_q[idx_q];

    // Same transition function evaluated twice: without snoop info at EVAL
    // (decides the bus op), and with the returned snoop at bus_ack (final state).
    mesi_next_state #(.MOESI_EN(MOESI_EN)) u_ns_eval (
        .state_i (cur_state),
        .cmd_i   (cmd_q),
        .snoop_i (SNP_NOHIT),
        .ns_o    (ns_eval)
    );

    mesi_next_state #(.MOESI_EN(MOESI_EN)) u_ns_ack (
        .state_i (cur_state),
        .cmd_i   (cmd_q),
        .snoop_i (bus_snoop),
        .ns_o    (ns_ack)
    );

    always_comb begin
        fsm_d    = fsm_q;
        cmd_d    = cmd_q;
        idx_d    = idx_q;
        clr_d    = clr_q;
        ns_d     = ns_q;
        wr_en    = 1'b0;
        wr_idx   = idx_q;
        wr_state = ns_q.next;
        case (fsm_q)
            S_IDLE: begin
                if (req_valid) begin
                    cmd_d = req_cmd;
                    idx_d = req_idx;
                    if (req_cmd == CMD_CLR) begin
                        clr_d = '0;
                        fsm_d = S_CLEAR;
                    end else begin
                        fsm_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                ns_d  = ns_eval;
                fsm_d = (ns_eval.busop == BUS_NOP) ? S_COMMIT : S_BUS;
            end
            S_BUS: begin
                if (bus_ack) begin
                    ns_d  = ns_ack;
                    fsm_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                wr_en = 1'b1;
                fsm_d = S_IDLE;
            end
            S_CLEAR: begin
                // The commit after the sweep rewrites idx_q with Invalid, which is harmless
                wr_en    = 1'b1;
                wr_idx   = clr_q;
                wr_state = ST_I;
                clr_d    = clr_q + IDX_W'(1);
                if (clr_q == LAST_IDX) begin
                    ns_d  = NS_IDLE;
                    fsm_d = S_COMMIT;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
            cmd_q <= '0;
            idx_q <= '0;
            clr_q <= '0;
            ns_q  <= NS_IDLE;
            for (int i = 0; i < NUM_LINES; i++) lines_q[i] <= ST_I;
        end else begin
            fsm_q <= fsm_d;
            cmd_q <= cmd_d;
            idx_q <= idx_d;
            clr_q <= clr_d;
            ns_q  <= ns_d;
            if (wr_en) lines_q[wr_idx] <= wr_state;
        end
    end

    assign req_ready  = (fsm_q == S_IDLE);
    assign bus_valid  = (fsm_q == S_BUS);
    assign bus_op     = (fsm_q == S_BUS) ? ns_q.busop : BUS_NOP;
    assign bus_idx    = idx_q;
    assign resp_valid = (fsm_q == S_COMMIT);
    assign resp_state = ns_q.next;
    assign resp_err   = ns_q.err;

endmodule

// File: tb/tb_mesi_line_controller.sv
// Directed bench for mesi_line_controller: unit 0 is MESI, unit 1 is MOESI.
module tb_mesi_line_controller;
    import mesi_pkg::*;

    localparam int NL = 64;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          req_valid [2];
    logic          req_ready [2];
    logic [3:0]    req_cmd   [2];
    logic [IW-1:0] req_idx   [2];
    logic          bus_valid [2];
    logic [2:0]    bus_op    [2];
    logic [IW-1:0] bus_idx   [2];
    logic          bus_ack   [2];
    logic [1:0]    bus_snoop [2];
    logic          resp_valid[2];
    logic [2:0]    resp_state[2];
    logic          resp_err  [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0]    r_st, r_op;
    logic          r_err, r_saw;
    logic [IW-1:0] r_bidx;
    int            r_held, r_lat;

    always #5 clk = ~clk;

    mesi_line_controller #(.NUM_LINES(NL), .MOESI_EN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_cmd(req_cmd[0]), .req_idx(req_idx[0]),
        .bus_valid(bus_valid[0]), .bus_op(bus_op[0]), .bus_idx(bus_idx[0]),
        .bus_ack(bus_ack[0]), .bus_snoop(bus_snoop[0]),
        .resp_valid(resp_valid[0]), .resp_state(resp_state[0]), .resp_err(resp_err[0])
    );

    mesi_line_controller #(.NUM_LINES(NL), .MOESI_EN(1'b1)) dut_o (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_cmd(req_cmd[1]), .req_idx(req_idx[1]),
        .bus_valid(bus_valid[1]), .bus_op(bus_op[1]), .bus_idx(bus_idx[1]),
        .bus_ack(bus_ack[1]), .bus_snoop(bus_snoop[1]),
        .resp_valid(resp_valid[1]), .resp_state(resp_state[1]), .resp_err(resp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one command on unit u; ack any bus op after dly held cycles with snp.
    task automatic run_cmd(input int u, input logic [3:0] cmd, input logic [IW-1:0] idx,
                           input logic [1:0] snp, input int dly, input string tag);
        int n, bc;
        logic done;
        n = 0; bc = 0; done = 1'b0;
        r_st = 'x; r_err = 1'bx; r_op = BUS_NOP; r_saw = 1'b0; r_bidx = '0; r_held = 0;
        @(negedge clk);
        req_valid[u] = 1'b1; req_cmd[u] = cmd; req_idx[u] = idx;
        @(negedge clk);
        req_valid[u] = 1'b0;
        while (n < 300 && !done) begin
            if (resp_valid[u]) begin
                done  = 1'b1;
                r_st  = resp_state[u];
                r_err = resp_err[u];
            end else begin
                if (bus_valid[u]) begin
                    r_saw  = 1'b1;
                    r_op   = bus_op[u];
                    r_bidx = bus_idx[u];
                    if (bc == dly) begin
                        bus_ack[u]   = 1'b1;
                        bus_snoop[u] = snp;
                    end else if (!req_ready[u]) begin
                        r_held++;
                    end
                    bc++;
                end
                @(negedge clk);
                bus_ack[u] = 1'b0;
                n++;
            end
        end
        r_lat = n + 1;
        chk({tag, "_done"}, done, 1);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_cmd[u] = '0; req_idx[u] = '0;
            bus_ack[u] = 1'b0; bus_snoop[u] = SNP_NOHIT;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready[0], 1);
        chk("rst_busv", bus_valid[0], 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busop", bus_op[0], BUS_NOP);
        chk("rst_busidx", bus_idx[0], 0);
        chk("rst_respv", resp_valid[0], 0);
        chk("rst_rstate", resp_state[0], ST_I);
        chk("rst_rerr", resp_err[0], 0);

        // Fills: HIT -> S, NoHIT -> E
        run_cmd(0, CMD_DRD, 5, SNP_HIT, 0, "rd5");
        chk("rd5_op", r_op, BUS_MRD); chk("rd5_bidx", r_bidx, 5);
        chk("rd5_st", r_st, ST_S); chk("rd5_lat", r_lat, 3);
        run_cmd(0, CMD_DRD, 6, SNP_NOHIT, 0, "rd6");
        chk("rd6_op", r_op, BUS_MRD); chk("rd6_st", r_st, ST_E);

        // I -> M via RFO, then SnoopRead forces writeback to S
        run_cmd(0, CMD_DWR, 3, SNP_NOHIT, 0, "wr3");
        chk("wr3_op", r_op, BUS_RFO); chk("wr3_st", r_st, ST_M);
        run_cmd(0, CMD_SRD, 3, SNP_NOHIT, 0, "srd3");
        chk("srd3_op", r_op, BUS_MWR); chk("srd3_st", r_st, ST_S);

        // MOESI unit: SnoopRead on M gives O without a bus op
        run_cmd(1, CMD_DWR, 3, SNP_NOHIT, 0, "o_wr3");
        chk("o_wr3_st", r_st, ST_M);
        run_cmd(1, CMD_SRD, 3, SNP_NOHIT, 0, "o_srd3");
        chk("o_srd3_bus", r_saw, 0); chk("o_srd3_st", r_st, ST_O);
        run_cmd(1, CMD_DWR, 3, SNP_NOHIT, 0, "o_wr3b");
        chk("o_wr3b_op", r_op, BUS_INV); chk("o_wr3b_st", r_st, ST_M);

        // S -> M with invalidate, bus_ack withheld 10 cycles
        run_cmd(0, CMD_DRD, 9, SNP_HITM, 0, "rd9");
        chk("rd9_st", r_st, ST_S);
        run_cmd(0, CMD_DWR, 9, SNP_NOHIT, 10, "wr9");
        chk("wr9_op", r_op, BUS_INV); chk("wr9_held", r_held, 10);
        chk("wr9_bidx", r_bidx, 9); chk("wr9_st", r_st, ST_M);

        // Illegal snoops and undefined command leave the state alone
        run_cmd(0, CMD_DRD, 2, SNP_NOHIT, 0, "rd2");
        chk("rd2_st", r_st, ST_E);
        run_cmd(0, CMD_SWR, 2, SNP_NOHIT, 0, "swr2");
        chk("swr2_err", r_err, 1); chk("swr2_st", r_st, ST_E);
        chk("swr2_bus", r_saw, 0); chk("swr2_lat", r_lat, 2);
        run_cmd(0, CMD_DRD, 2, SNP_NOHIT, 0, "rd2b");
        chk("rd2b_bus", r_saw, 0); chk("rd2b_st", r_st, ST_E); chk("rd2b_err", r_err, 0);
        run_cmd(0, 4'd7, 2, SNP_NOHIT, 0, "undef");
        chk("undef_err", r_err, 1); chk("undef_st", r_st, ST_E);
        run_cmd(0, CMD_SINV, 6, SNP_NOHIT, 0, "sinv6");
        chk("sinv6_err", r_err, 1); chk("sinv6_st", r_st, ST_E);
        run_cmd(0, CMD_SINV, 5, SNP_NOHIT, 0, "sinv5");
        chk("sinv5_err", r_err, 0); chk("sinv5_st", r_st, ST_I);

        // Stray ack while idle does nothing
        @(negedge clk); bus_ack[0] = 1'b1;
        @(negedge clk); bus_ack[0] = 1'b0;
        chk("stray_respv", resp_valid[0], 0);
        chk("stray_ready", req_ready[0], 1);

        // Fill every line, then sweep
        for (int i = 0; i < NL; i++) run_cmd(0, CMD_DWR, IW'(i), SNP_NOHIT, 0, "fill");
        run_cmd(0, CMD_CLR, 0, SNP_NOHIT, 0, "clr");
        chk("clr_lat", r_lat, NL + 1); chk("clr_st", r_st, ST_I);
        chk("clr_bus", r_saw, 0); chk("clr_err", r_err, 0);
        run_cmd(0, CMD_SRD, 0, SNP_NOHIT, 0, "c0");
        chk("c0_st", r_st, ST_I); chk("c0_bus", r_saw, 0);
        run_cmd(0, CMD_SRD, 17, SNP_NOHIT, 0, "c17");
        chk("c17_st", r_st, ST_I); chk("c17_bus", r_saw, 0);
        run_cmd(0, CMD_SRD, 63, SNP_NOHIT, 0, "c63");
        chk("c63_st", r_st, ST_I); chk("c63_bus", r_saw, 0);

        // Reset while a bus op is outstanding
        run_cmd(0, CMD_DWR, 10, SNP_NOHIT, 0, "m10");
        chk("m10_st", r_st, ST_M);
        @(negedge clk);
        req_valid[0] = 1'b1; req_cmd[0] = CMD_DWR; req_idx[0] = 11;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("pre_rst_busv", bus_valid[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busv", bus_valid[0], 0);
        chk("arst_busop", bus_op[0], BUS_NOP);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", req_ready[0], 1);
        chk("post_rst_busv", bus_valid[0], 0);
        run_cmd(0, CMD_SRD, 10, SNP_NOHIT, 0, "r10");
        chk("r10_st", r_st, ST_I); chk("r10_bus", r_saw, 0);
        run_cmd(1, CMD_SRD, 3, SNP_NOHIT, 0, "o_r3");
        chk("o_r3_st", r_st, ST_I);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
